bitonic_stream_adapter: RTL
===========================

Name: bitonic_stream_adapter

Overview:
- Wraps the 8-input, 1-register-stage bitonic sorter so it can be fed from a serial valid/ready sample stream.
- Collects up to 8 signed samples into a frame and pads short frames with the maximum signed value.
- Launches the sort and captures the result, then emits the real elements serially in ascending order with a last flag.
- Sits between the sample source and downstream consumers of sorted frames.

Parameters:
N, 7, sample width in bits (signed two's complement)
FRAME, 8, frame size; a localparam fixed at 8 to match the sorter

Ports:
clk  input  1  single clock; everything is on the rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  in_data is valid
in_ready  output  1  block can accept a sample this cycle
in_data  input  N  signed sample
in_last  input  1  marks the final sample of a short frame; ignored unless in_valid && in_ready
out_valid  output  1  out_data is valid
out_ready  input  1  consumer accepts out_data
out_data  output  N  signed sorted sample
out_last  output  1  marks the final real element of the frame

Behaviour:
- Reset (asynchronous, rst_n low): all state clears immediately.
  - in_ready=1, out_valid=0, out_data=0, out_last=0.
  - Fill count=0, pending=0, output buffer empty.
  - Any partial or in-flight frame is discarded with no output.
- Input side: a sample is accepted when in_valid && in_ready.
  - It is written to fill slot[fill_cnt]; fill_cnt increments.
  - The frame closes when fill_cnt reaches 8, or when the accepted sample has in_last=1.
  - On close, slots fill_cnt+1..7 are loaded with 2^(N-1)-1 (most positive value).
  - real_cnt (1..8) is recorded; frame_full=1.
  - in_ready = !frame_full.
- Sorter inputs a..h are driven continuously from fill slots 0..7.
- Launch: the launch cycle is any cycle with frame_full=1, output buffer empty, and pending=0.
  - At the end of the launch cycle, the sorter register captures the sorted frame.
  - frame_full and fill_cnt clear, and real_cnt moves to pend_cnt; pending=1.
  - in_ready rises in the following cycle.
- Capture: in the cycle after launch, sorter outputs i..p are valid.
  - At the end of that cycle they are copied to the output buffer: ob[0]=i ... ob[7]=p.
  - out_cnt=pend_cnt, rd_ptr=0, pending=0.
- Output side:
  - out_valid=1 while the output buffer is non-empty.
  - out_data=ob[rd_ptr]; out_last = (rd_ptr==out_cnt-1).
  - On out_valid && out_ready, rd_ptr increments; on the out_last beat the buffer becomes empty.
  - out_data and out_last hold stable while out_valid && !out_ready.
  - When the buffer is empty, out_data=0 and out_last=0.
- Latency: the frame closes at edge E. If the block is otherwise idle, the launch cycle starts at E, the capture edge is E+2, and out_valid=1 in the cycle after E+2.
- Overlap:
  - Filling of the next frame proceeds while the current frame drains.
  - A second frame that closes waits with frame_full=1 (in_ready=0) until the output buffer is empty.
  - The buffer reads as empty in the cycle after the out_last handshake, never in the same cycle.
- Ordering and ties:
  - Output is ascending signed order; equal values are interchangeable.
  - Padding values are never emitted. Only the first real_cnt sorted values are output; these equal the real multiset because the padding sorts last.
- Boundary conditions:
  - in_last on the very first sample gives a 1-element frame.
  - in_last on the 8th sample is a normal full frame.
  - A simultaneous in-accept and out-handshake in the same cycle is legal.
  - The fill and drain counters never wrap beyond 7.
  - Reset during the capture cycle or during drain drops the frame; out_valid falls asynchronously.
- Control FSM: FILL -> HOLD (frame_full, waiting on output) -> LAUNCH -> CAPTURE -> FILL.
  - LAUNCH is taken directly from FILL/HOLD when the launch condition holds.
  - The output buffer is tracked by an independent empty/drain flag.

Decomposition:
- Shared package holds:
  - FRAME=8;
  - a function for the signed maximum pad value, 2^(N-1)-1;
  - the FSM state encoding FILL/HOLD/LAUNCH/CAPTURE.
- One sub-module instance: two_stages_bitonic_sorter #(.N(N)), clocked by clk/rst_n.
- No further hierarchy. The fill slots, output buffer and counters are local.

Test Plan:
- Full frame with out_ready=1: inputs 5,-3,7,0,-64,63,2,-1 -> outputs -64,-3,-1,0,2,5,7,63; out_last on 63; first out_valid 3 cycles after the 8th accept edge.
- Short frame: 4,-2,9 with in_last on 9 -> outputs -2,4,9 only, out_last on 9, no 63 padding emitted; real value 63 in a short frame is emitted correctly.
- Back-pressure: out_ready=0 for 5 cycles mid-frame -> out_data/out_last held stable. The next frame fills, then in_ready=0 until drain completes, then launches.
- Back-to-back frames: 24 samples streamed continuously, out_ready=1 -> three correct sorted frames in order; nothing is lost or duplicated.
- Single element: 10 with in_last -> one beat, out_data=10, out_last=1.
- Async reset mid-drain: assert rst_n low after 3 output beats -> out_valid=0 immediately, in_ready=1 after release. The next frame 1..8 yields 1..8 with no stale data.

Source files
------------

// File: rtl/bitonic_stream_adapter_pkg.sv
// Shared definitions for the bitonic stream adapter.
//   FRAME       : samples per sort frame (fixed by the 8-input sorter)
//   ST_*        : control FSM state encoding
//   signed_max  : most positive two's complement value for a given width,
//                 used to pad short frames so the padding sorts last
package bitonic_stream_adapter_pkg;

  localparam int FRAME = 8;

  localparam logic [1:0] ST_FILL    = 2'd0;
  localparam logic [1:0] ST_HOLD    = 2'd1;
  localparam logic [1:0] ST_LAUNCH  = 2'd2;
  localparam logic [1:0] ST_CAPTURE = 2'd3;

  function automatic int signed_max(input int width);
    return (1 << (width - 1)) - 1;
  endfunction

endpackage

// File: rtl/two_stages_bitonic_sorter.sv
// 8-input bitonic sorter: a combinational compare-exchange network followed
// by one register stage. Outputs i..p are the ascending signed sort of the
// a..h values present in the previous cycle.
//   clk, rst_n : clock, asynchronous active-low reset (clears outputs)
//   a..h       : N-bit signed inputs
//   i..p       : N-bit signed sorted outputs, i smallest, p largest
module two_stages_bitonic_sorter #(
  parameter int N = 7
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [N-1:0] c,
  input  logic [N-1:0] d,
  input  logic [N-1:0] e,
  input  logic [N-1:0] f,
  input  logic [N-1:0] g,
  input  logic [N-1:0] h,
  output logic [N-1:0] i,
  output logic [N-1:0] j,
  output logic [N-1:0] k,
  output logic [N-1:0] l,
  output logic [N-1:0] m,
  output logic [N-1:0] n,
  output logic [N-1:0] o,
  output logic [N-1:0] p
);

  logic [N-1:0] net [8];
  logic [N-1:0] tmp;
  logic [2:0]   lo;
  logic [2:0]   hi;

  // Standard bitonic network: blk is the merge block size, dst the
  // compare distance. Lanes whose bit blk is clear sort ascending, the
  // others descending; the final blk=8 merge is ascending everywhere.
  always_comb begin
    tmp    = '0;
    lo     = '0;
    hi     = '0;
    net[0] = a;
    net[1] = b;
    net[2] = c;
    net[3] = d;
    net[4] = e;
    net[5] = f;
    net[6] = g;
    net[7] = h;
    for (int blk = 2; blk <= 8; blk = blk * 2) begin
      for (int dst = blk / 2; dst > 0; dst = dst / 2) begin
        for (int x = 0; x < 8; x++) begin
          if ((x ^ dst) > x) begin
            lo = 3'(x);
            hi = 3'(x ^ dst);
            if ((((x & blk) == 0) && ($signed(net[lo]) > $signed(net[hi]))) ||
                (((x & blk) != 0) && ($signed(net[lo]) < $signed(net[hi])))) begin
              tmp     = net[lo];
              net[lo] = net[hi];
              net[hi] = tmp;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i <= '0;
      j <= '0;
      k <= '0;
      l <= '0;
      m <= '0;
      n <= '0;
      o <= '0;
      p <= '0;
    end else begin
      i <= net[0];
      j <= net[1];
      k <= net[2];
      l <= net[3];
      m <= net[4];
      n <= net[5];
      o <= net[6];
      p <= net[7];
    end
  end

endmodule

// File: rtl/bitonic_stream_adapter.sv
// Serial front/back end for the 8-input bitonic sorter. Collects up to 8
// signed samples per frame (in_last closes a short frame early, remaining
// slots padded with the most positive value), sorts them, and streams the
// real elements back out in ascending order with a last flag.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid/in_ready    : input handshake; in_data sample, in_last frame end
//   out_valid/out_ready  : output handshake; out_data sorted sample,
//                          out_last on the final real element of the frame
//
// state      | meaning
// FILL       | accepting samples into the fill slots
// HOLD       | frame closed, waiting for the output buffer to drain
// LAUNCH     | sorter register captures the frame at the end of this cycle
// CAPTURE    | sorter outputs valid, copied to the output buffer at end
module bitonic_stream_adapter
  import bitonic_stream_adapter_pkg::*;
#(
  parameter int N = 7
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic         out_last
);

  localparam logic [N-1:0] PAD = N'(signed_max(N));

  logic [1:0]   state;
  logic [1:0]   state_nxt;
  logic [N-1:0] slot [FRAME];
  logic [N-1:0] srt  [FRAME];
  logic [N-1:0] ob   [FRAME];
  logic [2:0]   fill_cnt;
  logic [3:0]   real_cnt;
  logic [3:0]   pend_cnt;
  logic [3:0]   out_cnt;
  logic [2:0]   rd_ptr;
  logic         ob_valid;
  logic         accept;
  logic         close;
  logic         out_hs;
  logic         last_beat;
  logic         ob_empty_nxt;

  assign in_ready  = (state != ST_HOLD) && (state != ST_LAUNCH);
  assign accept    = in_valid && in_ready;
  assign close     = accept && (in_last || (fill_cnt == 3'd7));
  assign last_beat = ob_valid && ({1'b0, rd_ptr} == (out_cnt - 4'd1));
  assign out_hs    = ob_valid && out_ready;

  // The buffer only reads empty the cycle after the out_last handshake, so
  // a launch decided here lands exactly on the first empty cycle.
  assign ob_empty_nxt = !ob_valid || (out_hs && last_beat);

  assign out_valid = ob_valid;
  assign out_data  = ob_valid ? ob[rd_ptr] : '0;
  assign out_last  = last_beat;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_FILL:    if (close) state_nxt = ob_empty_nxt ? ST_LAUNCH : ST_HOLD;
      ST_HOLD:    if (ob_empty_nxt) state_nxt = ST_LAUNCH;
      ST_LAUNCH:  state_nxt = ST_CAPTURE;
      // A frame closing during capture must wait: the buffer fills this edge.
      ST_CAPTURE: state_nxt = close ? ST_HOLD : ST_FILL;
      default:    state_nxt = ST_FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_FILL;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < FRAME; s++) slot[s] <= '0;
      fill_cnt <= '0;
      real_cnt <= '0;
    end else if (accept) begin
      slot[fill_cnt] <= in_data;
      if (close) begin
        for (int s = 0; s < FRAME; s++) begin
          if (3'(s) > fill_cnt) slot[s] <= PAD;
        end
        fill_cnt <= '0;
        real_cnt <= {1'b0, fill_cnt} + 4'd1;
      end else begin
        fill_cnt <= fill_cnt + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_cnt <= '0;
    end else if (state == ST_LAUNCH) begin
      pend_cnt <= real_cnt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < FRAME; s++) ob[s] <= '0;
      out_cnt  <= '0;
      rd_ptr   <= '0;
      ob_valid <= 1'b0;
    end else if (state == ST_CAPTURE) begin
      for (int s = 0; s < FRAME; s++) ob[s] <= srt[s];
      out_cnt  <= pend_cnt;
      rd_ptr   <= '0;
      ob_valid <= 1'b1;
    end else if (out_hs) begin
      if (last_beat) begin
        ob_valid <= 1'b0;
        rd_ptr   <= '0;
      end else begin
        rd_ptr <= rd_ptr + 3'd1;
      end
    end
  end

  two_stages_bitonic_sorter #(.N(N)) u_sorter (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (slot[0]),
    .b     (slot[1]),
    .c     (slot[2]),
    .d     (slot[3]),
    .e     (slot[4]),
    .f     (slot[5]),
    .g     (slot[6]),
    .h     (slot[7]),
    .i     (srt[0]),
    .j     (srt[1]),
    .k     (srt[2]),
    .l     (srt[3]),
    .m     (srt[4]),
    .n     (srt[5]),
    .o     (srt[6]),
    .p     (srt[7])
  );

endmodule
